// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: instruction width, reset PC, NOP and the base opcode map.
package if_stage_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [ILEN-1:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0

   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
   localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_OP     = 7'b011_0011;
   localparam logic [6:0] OPC_LUI    = 7'b011_0111;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC_JALR   = 7'b110_0111;
   localparam logic [6:0] OPC_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

   function automatic logic word_aligned(input logic [XLEN-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble wins over load; with neither asserted the contents hold.
module if_id_reg
   import if_stage_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            bubble_i,
   input  logic [ILEN-1:0] inst_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] pc_plus4_i,
   output logic [ILEN-1:0] inst_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic            valid_o
);

   logic [ILEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
   logic            valid_q, valid_d;

   always_comb begin
      inst_d     = inst_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (bubble_i) begin
         // Bubbles keep the last PC so downstream PC-relative views stay stable.
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end else if (load_i) begin
         inst_d     = inst_i;
         pc_d       = pc_i;
         pc_plus4_d = pc_plus4_i;
         valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inst_q     <= NOP_INST;
         pc_q       <= '0;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         inst_q     <= inst_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   assign inst_o     = inst_q;
   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect/stall/flush arbitration and IF/ID register.
// Optional IF_MISALIGN_TRAP_EN: trap and hold fetch on misaligned redirect targets.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic [XLEN-1:0] imem_addr_o,
   output logic            imem_req_o,
   input  logic            imem_ready_i,
   input  logic [ILEN-1:0] imem_rdata_i,
   output logic [ILEN-1:0] id_inst_o,
   output logic [XLEN-1:0] id_pc_o,
   output logic [XLEN-1:0] id_pc_plus4_o,
   output logic            id_valid_o,
   output logic            fetch_misalign_o
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus4;
   logic            misalign_q;
   logic            accept;
   logic            ifid_load;
   logic            ifid_bubble;

`ifdef IF_MISALIGN_TRAP_EN
   logic misalign_d;

   always_comb begin
      misalign_d = misalign_q;
      if (redirect_valid_i) begin
         misalign_d = !word_aligned(redirect_pc_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end
`else
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc_i[1:0];
   assign misalign_q          = 1'b0;
`endif

   assign pc_plus4    = pc_q + 32'd4;
   assign imem_addr_o = pc_q;
   assign imem_req_o  = !rst_i && !misalign_q;
   assign accept      = imem_req_o && imem_ready_i && !stall_i;

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid_i) begin
`ifdef IF_MISALIGN_TRAP_EN
         pc_d = redirect_pc_i;
`else
         pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
`endif
      end else if (accept) begin
         pc_d = pc_plus4;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Returned words are dropped in redirect/flush cycles; an unstalled cycle with no accept
   // (memory wait or misalign hold) inserts a bubble.
   assign ifid_bubble = redirect_valid_i || flush_i || misalign_q || (!stall_i && !accept);
   assign ifid_load   = accept && !redirect_valid_i && !flush_i;

   if_id_reg u_if_id_reg (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (ifid_load),
      .bubble_i   (ifid_bubble),
      .inst_i     (imem_rdata_i),
      .pc_i       (pc_q),
      .pc_plus4_i (pc_plus4),
      .inst_o     (id_inst_o),
      .pc_o       (id_pc_o),
      .pc_plus4_o (id_pc_plus4_o),
      .valid_o    (id_valid_o)
   );

   assign fetch_misalign_o = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming fetch, stall, memory wait, redirect, flush,
// misaligned redirect (both IF_MISALIGN_TRAP_EN builds), PC wrap and reset during stall.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, redirect_valid, imem_ready;
   logic [31:0] redirect_pc, imem_rdata;
   logic [31:0] imem_addr, id_inst, id_pc, id_pc_plus4;
   logic        imem_req, id_valid, fetch_misalign;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] IA  = 32'hAAAA_0001;
   localparam logic [31:0] IB  = 32'hBBBB_0002;
   localparam logic [31:0] IC  = 32'hCCCC_0003;
   localparam logic [31:0] ID  = 32'hDDDD_0004;
   localparam logic [31:0] IE  = 32'hEEEE_0005;
   localparam logic [31:0] IF  = 32'hFFFF_0006;
   localparam logic [31:0] IG  = 32'h1234_5677;
   localparam logic [31:0] IH  = 32'h7654_3211;

   always #5 clk = ~clk;

   if_stage dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .stall_i          (stall),
      .flush_i          (flush),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .imem_addr_o      (imem_addr),
      .imem_req_o       (imem_req),
      .imem_ready_i     (imem_ready),
      .imem_rdata_i     (imem_rdata),
      .id_inst_o        (id_inst),
      .id_pc_o          (id_pc),
      .id_pc_plus4_o    (id_pc_plus4),
      .id_valid_o       (id_valid),
      .fetch_misalign_o (fetch_misalign)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_id(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                         input logic valid);
      chk({tag, ".inst"}, id_inst, inst);
      chk({tag, ".pc"}, id_pc, pc);
      chk({tag, ".pc4"}, id_pc_plus4, pc + 32'd4);
      chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, valid});
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; imem_ready = 1'b0; imem_rdata = '0;
      step(); step();
      chk("rst.inst", id_inst, NOP);
      chk("rst.pc", id_pc, 32'h0);
      chk("rst.pc4", id_pc_plus4, 32'h0);
      chk("rst.valid", {31'd0, id_valid}, 32'd0);
      chk("rst.addr", imem_addr, 32'h0);
      chk("rst.req", {31'd0, imem_req}, 32'd0);
      chk("rst.mis", {31'd0, fetch_misalign}, 32'd0);

      rst = 1'b0; #1;
      chk("run.req", {31'd0, imem_req}, 32'd1);

      // Streaming fetch A, B
      imem_ready = 1'b1; imem_rdata = IA; step();
      chk_id("fetchA", IA, 32'h0, 1'b1);
      chk("fetchA.addr", imem_addr, 32'h4);
      imem_rdata = IB; step();
      chk_id("fetchB", IB, 32'h4, 1'b1);
      chk("fetchB.addr", imem_addr, 32'h8);

      // Two-cycle stall at PC 8
      stall = 1'b1; imem_rdata = IC;
      for (int i = 0; i < 2; i++) begin
         step();
         chk_id("stall", IB, 32'h4, 1'b1);
         chk("stall.addr", imem_addr, 32'h8);
      end
      stall = 1'b0; step();
      chk_id("fetchC", IC, 32'h8, 1'b1);
      chk("fetchC.addr", imem_addr, 32'hC);

      // Memory wait: bubbles, PC and id_pc held
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_id("wait", NOP, 32'h8, 1'b0);
         chk("wait.addr", imem_addr, 32'hC);
      end
      imem_ready = 1'b1; imem_rdata = ID; step();
      chk_id("fetchD", ID, 32'hC, 1'b1);
      chk("fetchD.addr", imem_addr, 32'h10);

      // Redirect overrides stall
      redirect_valid = 1'b1; redirect_pc = 32'h100; stall = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      chk("redir.addr", imem_addr, 32'h100);
      chk_id("redir", NOP, 32'hC, 1'b0);
      redirect_valid = 1'b0; stall = 1'b0; imem_rdata = IE; step();
      chk_id("fetchE", IE, 32'h100, 1'b1);
      chk("fetchE.addr", imem_addr, 32'h104);

      // Flush: word dropped, PC still advances
      flush = 1'b1; imem_rdata = IF; step();
      chk_id("flush", NOP, 32'h100, 1'b0);
      chk("flush.addr", imem_addr, 32'h108);
      flush = 1'b0;

      // Misaligned redirect
      redirect_valid = 1'b1; redirect_pc = 32'h102; step();
      redirect_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      chk("mis.addr", imem_addr, 32'h102);
      chk("mis.flag", {31'd0, fetch_misalign}, 32'd1);
      chk("mis.req", {31'd0, imem_req}, 32'd0);
      step();
      chk("mis.hold.addr", imem_addr, 32'h102);
      chk("mis.hold.flag", {31'd0, fetch_misalign}, 32'd1);
      chk("mis.hold.valid", {31'd0, id_valid}, 32'd0);
`else
      chk("mis.addr", imem_addr, 32'h100);
      chk("mis.flag", {31'd0, fetch_misalign}, 32'd0);
      chk("mis.req", {31'd0, imem_req}, 32'd1);
`endif
      redirect_valid = 1'b1; redirect_pc = 32'h200; step();
      redirect_valid = 1'b0;
      chk("align.addr", imem_addr, 32'h200);
      chk("align.flag", {31'd0, fetch_misalign}, 32'd0);
      chk("align.req", {31'd0, imem_req}, 32'd1);

      // PC wrap
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; step();
      redirect_valid = 1'b0;
      chk("wrap.pre", imem_addr, 32'hFFFF_FFFC);
      imem_rdata = IG; step();
      chk("wrap.inst", id_inst, IG);
      chk("wrap.pc", id_pc, 32'hFFFF_FFFC);
      chk("wrap.pc4", id_pc_plus4, 32'h0);
      chk("wrap.addr", imem_addr, 32'h0);

      // Reset asserted during stall
      stall = 1'b1; imem_rdata = IH; step();
      chk("stall2.inst", id_inst, IG);
      rst = 1'b1; step();
      chk("srst.inst", id_inst, NOP);
      chk("srst.pc", id_pc, 32'h0);
      chk("srst.pc4", id_pc_plus4, 32'h0);
      chk("srst.valid", {31'd0, id_valid}, 32'd0);
      chk("srst.addr", imem_addr, 32'h0);
      chk("srst.req", {31'd0, imem_req}, 32'd0);
      rst = 1'b0; stall = 1'b0; step();
      chk_id("fetchH", IH, 32'h0, 1'b1);
      chk("fetchH.addr", imem_addr, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
